// File: rtl/ship_missile_ctl_if.sv
// ship_missile_ctl_if
// Groups the missile controller's control inputs and draw/collision outputs.
//   fire           : fire key level (already synchronised)
//   dead_s         : player dead strobe/level
//   hit            : collision detector hit pulse
//   xpos_ship      : ship x position (11 bits)
//   missile_x/y    : missile left column / top row (11 bits each)
//   missile_active : missile in flight
//   shot_pulse     : one-cycle pulse per launch
// master = the side driving the controls, slave = the missile controller.
interface ship_missile_ctl_if;
  logic        fire;
  logic        dead_s;
  logic        hit;
  logic [10:0] xpos_ship;
  logic [10:0] missile_x;
  logic [10:0] missile_y;
  logic        missile_active;
  logic        shot_pulse;

  modport master (
    output fire, dead_s, hit, xpos_ship,
    input  missile_x, missile_y, missile_active, shot_pulse
  );

  modport slave (
    input  fire, dead_s, hit, xpos_ship,
    output missile_x, missile_y, missile_active, shot_pulse
  );
endinterface

// File: rtl/ship_missile_ctl.sv
// ship_missile_ctl
// Player missile controller. A fresh fire press launches one missile from the
// ship's nose; the missile then climbs one pixel every STEP_LIMIT+1 cycles
// until it reaches Y_MIN, is reported hit, or the player dies.
// Ports:
//   pclk : pixel clock
//   rst  : synchronous active-high reset
//   bus  : ship_missile_ctl_if.slave (fire/dead_s/hit/xpos_ship in,
//          missile_x/missile_y/missile_active/shot_pulse out)
module ship_missile_ctl #(
  parameter int SHIP_Y     = 700,
  parameter int SHIP_W     = 83,
  parameter int MISSILE_W  = 4,
  parameter int MISSILE_H  = 16,
  parameter int Y_MIN      = 16,
  parameter int STEP_LIMIT = 20000
) (
  input logic               pclk,
  input logic               rst,
  ship_missile_ctl_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_FLY    = 2'd2;

  localparam logic [10:0] LAUNCH_DX = 11'((SHIP_W - MISSILE_W) / 2);
  localparam logic [10:0] LAUNCH_Y  = 11'(SHIP_Y - MISSILE_H);
  localparam logic [10:0] Y_TOP     = 11'(Y_MIN);
  localparam logic [20:0] STEP_LIM  = 21'(STEP_LIMIT);

  logic [1:0]  state_q, state_d;
  logic [20:0] step_cnt_q, step_cnt_d;
  logic        armed_q, armed_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        active_q, active_d;
  logic        shot_q, shot_d;

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    active_d   = active_q;
    shot_d     = 1'b0;
    armed_d    = armed_q;

    // Re-arm only once the key has been seen released.
    if (!bus.fire) armed_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        active_d = 1'b0;
        if (!bus.dead_s && bus.fire && armed_q) begin
          state_d    = ST_LAUNCH;
          x_d        = bus.xpos_ship + LAUNCH_DX;
          y_d        = LAUNCH_Y;
          active_d   = 1'b1;
          shot_d     = 1'b1;
          step_cnt_d = '0;
          armed_d    = 1'b0;
        end
      end
      ST_LAUNCH: begin
        // Launch always completes; a dead_s here is acted on in FLY.
        state_d = ST_FLY;
      end
      ST_FLY: begin
        if (bus.dead_s || bus.hit) begin
          state_d    = ST_IDLE;
          active_d   = 1'b0;
          step_cnt_d = '0;
        end else if (step_cnt_q == STEP_LIM) begin
          step_cnt_d = '0;
          // Compare before decrementing so the row never wraps below Y_MIN.
          if (y_q == Y_TOP) begin
            state_d  = ST_IDLE;
            active_d = 1'b0;
          end else begin
            y_d = y_q - 11'd1;
          end
        end else begin
          step_cnt_d = step_cnt_q + 21'd1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        active_d = 1'b0;
      end
    endcase

    if (bus.dead_s) armed_d = 1'b0;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      step_cnt_q <= '0;
      armed_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      active_q   <= 1'b0;
      shot_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      armed_q    <= armed_d;
      x_q        <= x_d;
      y_q        <= y_d;
      active_q   <= active_d;
      shot_q     <= shot_d;
    end
  end

  assign bus.missile_x      = x_q;
  assign bus.missile_y      = y_q;
  assign bus.missile_active = active_q;
  assign bus.shot_pulse     = shot_q;

endmodule

// File: tb/tb_ship_missile_ctl.sv
// tb_ship_missile_ctl
// Directed stimulus against ship_missile_ctl with STEP_LIMIT=3. A behavioural
// model derives the expected outputs from the launch time (row = start row
// minus elapsed steps) and is compared every cycle; literal checks pin the
// model to hand-computed values.
module tb_ship_missile_ctl;
  localparam int SHIP_Y     = 700;
  localparam int SHIP_W     = 83;
  localparam int MISSILE_W  = 4;
  localparam int MISSILE_H  = 16;
  localparam int Y_MIN      = 16;
  localparam int STEP_LIMIT = 3;

  localparam int PERIOD   = STEP_LIMIT + 1;
  localparam int START_Y  = SHIP_Y - MISSILE_H;        // 684
  localparam int OFFSET_X = (SHIP_W - MISSILE_W) / 2;  // 39
  localparam int N_STEPS  = START_Y - Y_MIN + 1;       // 669

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ship_missile_ctl_if bus ();

  ship_missile_ctl #(
    .SHIP_Y(SHIP_Y), .SHIP_W(SHIP_W), .MISSILE_W(MISSILE_W),
    .MISSILE_H(MISSILE_H), .Y_MIN(Y_MIN), .STEP_LIMIT(STEP_LIMIT)
  ) dut (
    .pclk(clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit model_valid = 1'b0;

  // Model state: whether a missile is in flight and how many edges ago it launched.
  bit m_fly    = 1'b0;
  int m_age    = 0;
  bit m_armed  = 1'b0;
  int m_x      = 0;
  int m_y      = 0;
  bit m_active = 1'b0;
  bit m_shot   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model: advanced on every rising edge from the inputs held across it.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_fly = 0; m_age = 0; m_armed = 0;
        m_x = 0; m_y = 0; m_active = 0; m_shot = 0;
      end else begin
        bit launch;
        launch = 1'b0;
        m_shot = 1'b0;
        if (m_fly) begin
          m_age++;
          // From the second edge after launch the missile is flying and can be aborted.
          if (m_age >= 2 && (bus.dead_s || bus.hit)) begin
            m_fly = 0; m_active = 0;
          end else if ((m_age - 1) / PERIOD >= N_STEPS) begin
            m_fly = 0; m_active = 0; m_y = Y_MIN;
          end else begin
            m_y = START_Y - (m_age - 1) / PERIOD;
          end
        end else if (!bus.dead_s && bus.fire && m_armed) begin
          launch = 1'b1;
          m_fly = 1; m_age = 0;
          m_x = (int'(bus.xpos_ship) + OFFSET_X) % 2048;
          m_y = START_Y; m_active = 1; m_shot = 1;
        end
        if (launch || bus.dead_s) m_armed = 1'b0;
        else if (!bus.fire)       m_armed = 1'b1;
      end
      model_valid = 1'b1;
    end
  end

  // Per-cycle compare of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        n_chk++;
        if (int'(bus.missile_x) == m_x && int'(bus.missile_y) == m_y &&
            bus.missile_active == m_active && bus.shot_pulse == m_shot)
          n_pass++;
        else
          $display("FAIL model cyc=%0d: got x=%0d y=%0d act=%0d shot=%0d expected x=%0d y=%0d act=%0d shot=%0d",
                   cyc, bus.missile_x, bus.missile_y, bus.missile_active, bus.shot_pulse,
                   m_x, m_y, m_active, m_shot);
        if (bus.shot_pulse)
          $display("launch cyc=%0d x=%0d y=%0d", cyc, bus.missile_x, bus.missile_y);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic launch_with(input int xpos);
    bus.fire = 1'b0;
    tick(1);
    bus.xpos_ship = 11'(xpos);
    bus.fire = 1'b1;
    tick(1);
  endtask

  initial begin
    int launch_cyc;
    int k;
    bus.fire = 1'b0; bus.dead_s = 1'b0; bus.hit = 1'b0; bus.xpos_ship = 11'd0;
    rst = 1'b1;
    tick(3);
    check("reset_x", int'(bus.missile_x), 0);
    check("reset_y", int'(bus.missile_y), 0);
    check("reset_active", int'(bus.missile_active), 0);
    check("reset_shot", int'(bus.shot_pulse), 0);
    rst = 1'b0;

    // Basic launch.
    tick(2);
    bus.xpos_ship = 11'd400;
    bus.fire = 1'b1;
    tick(1);
    launch_cyc = cyc;
    check("launch_x", int'(bus.missile_x), 439);
    check("launch_y", int'(bus.missile_y), 684);
    check("launch_active", int'(bus.missile_active), 1);
    check("launch_shot", int'(bus.shot_pulse), 1);
    tick(1);
    check("shot_clear", int'(bus.shot_pulse), 0);
    tick(3);
    check("y_before_step", int'(bus.missile_y), 684);
    tick(1);
    check("first_step_y", int'(bus.missile_y), 683);
    tick(4);
    check("second_step_y", int'(bus.missile_y), 682);

    // Full flight with fire held.
    k = 0;
    while (bus.missile_active && k < 5000) begin tick(1); k++; end
    check("flight_ended", int'(bus.missile_active), 0);
    check("flight_len", cyc - launch_cyc, 2677);
    check("end_y", int'(bus.missile_y), 16);
    tick(5);
    check("no_refire_held", int'(bus.missile_active), 0);

    // Re-arm, new x, x frozen during flight.
    launch_with(100);
    check("rearm_shot", int'(bus.shot_pulse), 1);
    check("rearm_x", int'(bus.missile_x), 139);
    bus.xpos_ship = 11'd700;
    tick(10);
    check("x_frozen", int'(bus.missile_x), 139);

    // Hit at row 600.
    k = 0;
    while (bus.missile_y != 11'd600 && k < 2000) begin tick(1); k++; end
    check("reach_600", int'(bus.missile_y), 600);
    bus.hit = 1'b1;
    tick(1);
    bus.hit = 1'b0;
    check("hit_active", int'(bus.missile_active), 0);
    check("hit_y", int'(bus.missile_y), 600);

    // Dead in FLY.
    launch_with(200);
    check("dead_launch_x", int'(bus.missile_x), 239);
    tick(10);
    bus.dead_s = 1'b1;
    tick(1);
    check("dead_active", int'(bus.missile_active), 0);
    bus.dead_s = 1'b0;

    // Dead plus fire in IDLE with armed set: no launch.
    bus.fire = 1'b0;
    tick(1);
    bus.dead_s = 1'b1;
    bus.fire = 1'b1;
    tick(3);
    check("dead_idle_active", int'(bus.missile_active), 0);
    bus.dead_s = 1'b0;
    tick(2);
    check("dead_disarms", int'(bus.missile_active), 0);

    // Reset mid-flight with fire held through release.
    launch_with(300);
    check("pre_rst_shot", int'(bus.shot_pulse), 1);
    tick(20);
    rst = 1'b1;
    tick(2);
    check("rst_x", int'(bus.missile_x), 0);
    check("rst_y", int'(bus.missile_y), 0);
    check("rst_active", int'(bus.missile_active), 0);
    rst = 1'b0;
    tick(5);
    check("rst_fire_held", int'(bus.missile_active), 0);
    launch_with(50);
    check("post_rst_launch", int'(bus.shot_pulse), 1);
    check("post_rst_x", int'(bus.missile_x), 89);
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
